// File: rtl/dcache_pkg.sv
// Shared widths, address field positions and FSM encodings for the
// direct-mapped write-back L1 data cache.
package dcache_pkg;

  localparam int DC_ADDR_W    = 32;
  localparam int DC_LINE_W    = 256;
  localparam int DC_NUM_LINES = 32;
  localparam int WORD_W       = 32;
  localparam int OFFSET_W     = 5;
  localparam int INDEX_W      = 5;
  localparam int TAG_W        = DC_ADDR_W - OFFSET_W - INDEX_W;
  localparam int WSEL_W       = 3;

  typedef logic [1:0] state_t;

  localparam state_t IDLE       = 2'd0;
  localparam state_t WRITEBACK  = 2'd1;
  localparam state_t READMISS   = 2'd2;
  localparam state_t READMISSOK = 2'd3;

  function automatic logic [WORD_W-1:0] line_word(input logic [DC_LINE_W-1:0] line,
                                                   input logic [WSEL_W-1:0]    sel);
    return line[{sel, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous full-line fill
// and single-word store; only valid/dirty are reset.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = DC_NUM_LINES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INDEX_W-1:0]   idx_i,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [DC_LINE_W-1:0] line_o,
  input  logic                 fill_i,
  input  logic [TAG_W-1:0]     fill_tag_i,
  input  logic [DC_LINE_W-1:0] fill_line_i,
  input  logic                 word_we_i,
  input  logic [WSEL_W-1:0]    word_sel_i,
  input  logic [WORD_W-1:0]    word_i
);

  logic [TAG_W-1:0]     tag_q   [NUM_LINES];
  logic [DC_LINE_W-1:0] data_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  // A fill always leaves the line clean; a store hit marks it dirty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_sel_i, 5'd0} +: WORD_W] <= word_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller: hit
// detection, pipeline stall and the line-wide miss/writeback handshake.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int ADDR_W    = DC_ADDR_W,
  parameter int LINE_W    = DC_LINE_W,
  parameter int NUM_LINES = DC_NUM_LINES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  state_t              state_q, state_d;
  logic                req_s, hit_s, fill_s, word_we_s;
  logic [INDEX_W-1:0]  idx_s;
  logic [TAG_W-1:0]    tag_s, line_tag_s;
  logic [WSEL_W-1:0]   wsel_s;
  logic                line_valid_s, line_dirty_s;
  logic [LINE_W-1:0]   line_s;
  logic                unused_addr_s;

  assign idx_s         = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign tag_s         = cpu_addr_i[OFFSET_W + INDEX_W +: TAG_W];
  assign wsel_s        = cpu_addr_i[2 +: WSEL_W];
  assign unused_addr_s = ^cpu_addr_i[1:0];

  assign req_s     = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit_s     = line_valid_s & (line_tag_s == tag_s);
  assign fill_s    = (state_q == READMISS) & mem_ack_i;
  assign word_we_s = (state_q == IDLE) & hit_s & cpu_MemWrite_i;

  // Reset gates the stall so the pipeline is released the moment rst_i falls.
  assign stall_o    = rst_i & req_s & ~((state_q == IDLE) & hit_s);
  assign cpu_data_o = cpu_MemRead_i ? line_word(line_s, wsel_s) : 32'd0;

  dcache_sram #(
    .NUM_LINES (NUM_LINES)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (idx_s),
    .tag_o       (line_tag_s),
    .valid_o     (line_valid_s),
    .dirty_o     (line_dirty_s),
    .line_o      (line_s),
    .fill_i      (fill_s),
    .fill_tag_i  (tag_s),
    .fill_line_i (mem_data_i),
    .word_we_i   (word_we_s),
    .word_sel_i  (wsel_s),
    .word_i      (cpu_data_i)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_s & ~hit_s) begin
          state_d = (line_valid_s & line_dirty_s) ? WRITEBACK : READMISS;
        end else begin
          state_d = IDLE;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) state_d = READMISS;
        else           state_d = WRITEBACK;
      end
      READMISS: begin
        if (mem_ack_i) state_d = READMISSOK;
        else           state_d = READMISS;
      end
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Memory-side outputs are pure decodes of the state.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {line_tag_s, idx_s, {OFFSET_W{1'b0}}};
        mem_data_o   = line_s;
      end
      READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {cpu_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      end
      default: begin
        mem_enable_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboarded bench for dcache_controller: flat-memory reference model,
// residency model for stall prediction, and a latency-programmable line memory.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .stall_o        (stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int          stall;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  int           ack_delay = 1;
  logic         force_ack = 1'b0;
  logic         exp_wb = 1'b0;
  logic [31:0]  exp_wb_addr = 32'd0;
  logic [31:0]  exp_rd_addr = 32'd0;

  logic [255:0] bmem    [logic [26:0]];
  logic [31:0]  ref_mem [logic [29:0]];
  logic         m_valid [32];
  logic         m_dirty [32];
  logic [21:0]  m_tag   [32];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] back_word(input logic [31:0] a);
    logic [255:0] l;
    if (bmem.exists(a[31:5])) begin
      l = bmem[a[31:5]];
      return l[{a[4:2], 5'd0} +: 32];
    end
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return back_word(a);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_word({la[31:5], 3'(w), 2'b00});
    return l;
  endfunction

  function automatic logic [255:0] back_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = back_word({la[31:5], 3'(w), 2'b00});
    return l;
  endfunction

  // Reset forgets residency and any store not yet written back.
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 22'd0;
    end
    ref_mem.delete();
  endtask

  // Line memory: acks after ack_delay enabled cycles, checks every request.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (force_ack) begin
        mem_ack_i  = 1'b1;
        mem_data_i = {8{$urandom}};
        force_ack  = 1'b0;
        cnt        = 0;
      end else if (mem_enable_o) begin
        cnt++;
        if (cnt >= ack_delay) begin
          cnt = 0;
          if (exp_wb) begin
            chk("wb_write", 256'(mem_write_o), 256'(1'b1));
            chk("wb_addr", 256'(mem_addr_o), 256'(exp_wb_addr));
            chk("wb_data", mem_data_o, ref_line(exp_wb_addr));
            bmem[mem_addr_o[31:5]] = mem_data_o;
            exp_wb = 1'b0;
          end else begin
            chk("rd_write", 256'(mem_write_o), 256'(1'b0));
            chk("rd_addr", 256'(mem_addr_o), 256'(exp_rd_addr));
            mem_data_i = back_line(mem_addr_o);
          end
          mem_ack_i = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: counts stall cycles and pops the scoreboard when an access retires.
  initial begin : monitor
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        stall_cnt = 0;
      end else if (cpu_MemRead_i || cpu_MemWrite_i) begin
        if (stall_o) begin
          stall_cnt++;
        end else begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 256'(1'b1), 256'(1'b0));
          end else begin
            e = exp_q.pop_front();
            if (e.is_read) chk("load_data", 256'(cpu_data_o), 256'(e.data));
            chk("stall_cycles", 256'(stall_cnt), 256'(e.stall));
            chk("idle_mem_enable", 256'(mem_enable_o), 256'(1'b0));
          end
          stall_cnt = 0;
          done_cnt++;
        end
      end
    end
  end

  task automatic do_access(input logic [31:0] a, input logic wr, input logic [31:0] d,
                           input int dly);
    exp_t        e;
    int          idx;
    int          start;
    logic        hit;
    logic [21:0] t;
    idx = int'(a[9:5]);
    t   = a[31:10];
    hit = m_valid[idx] && (m_tag[idx] == t);
    e.is_read = !wr;
    e.data    = ref_word(a);
    if (hit) begin
      e.stall = 0;
    end else if (m_dirty[idx]) begin
      e.stall     = 2 * dly + 2;
      exp_wb      = 1'b1;
      exp_wb_addr = {m_tag[idx], a[9:5], 5'b00000};
    end else begin
      e.stall = dly + 2;
    end
    exp_rd_addr = {a[31:5], 5'b00000};
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = t;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_dirty[idx]      = 1'b1;
      ref_mem[a[31:2]] = d;
    end
    exp_q.push_back(e);
    ack_delay      = dly;
    cpu_addr_i     = a;
    cpu_data_i     = d;
    cpu_MemRead_i  = !wr;
    cpu_MemWrite_i = wr;
    start = done_cnt;
    for (int c = 0; c < 200 && done_cnt == start; c++) @(posedge clk_i);
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: addr %h not retired within 200 cycles", a);
    end
    #1;
  endtask

  initial begin : stimulus
    logic [255:0] l;
    logic [31:0]  a;
    rst_i = 1'b0;
    cpu_addr_i = 32'h0000_0044;
    cpu_data_i = 32'd0;
    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_stall", 256'(stall_o), 256'(1'b0));
    chk("rst_mem_enable", 256'(mem_enable_o), 256'(1'b0));
    chk("rst_mem_write", 256'(mem_write_o), 256'(1'b0));
    chk("rst_mem_addr", 256'(mem_addr_o), 256'(32'd0));
    chk("rst_mem_data", mem_data_o, 256'(1'b0));
    chk("rst_cpu_data", 256'(cpu_data_o), 256'(32'd0));
    cpu_MemRead_i = 1'b1;
    #1;
    chk("rst_stall_with_req", 256'(stall_o), 256'(1'b0));
    cpu_MemRead_i = 1'b0;
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Preload the line at 0x40 so word1/word2 are known constants.
    l = back_line(32'h0000_0040);
    l[63:32] = 32'hDEAD_BEEF;
    l[95:64] = 32'h0BAD_F00D;
    bmem[27'h2] = l;

    do_access(32'h0000_0044, 1'b0, 32'd0, 10);
    chk("cold_miss_data", 256'(cpu_data_o), 256'(32'hDEAD_BEEF));
    do_access(32'h0000_0048, 1'b0, 32'd0, 10);
    chk("read_hit_data", 256'(cpu_data_o), 256'(32'h0BAD_F00D));
    do_access(32'h0000_0044, 1'b1, 32'h1234_5678, 1);
    do_access(32'h0000_0444, 1'b0, 32'd0, 3);
    do_access(32'h0000_0100, 1'b1, 32'hA5A5_A5A5, 4);
    do_access(32'h0000_0100, 1'b0, 32'd0, 1);
    chk("write_alloc_merge", 256'(cpu_data_o), 256'(32'hA5A5_A5A5));
    do_access(32'h0000_0500, 1'b0, 32'd0, 2);
    chk("evicted_merge_in_mem", 256'(back_word(32'h0000_0100)), 256'(32'hA5A5_A5A5));

    // Stray ack with no request outstanding.
    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
    force_ack = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("stray_stall", 256'(stall_o), 256'(1'b0));
    chk("stray_mem_enable", 256'(mem_enable_o), 256'(1'b0));
    do_access(32'h0000_0440, 1'b0, 32'd0, 5);

    // Reset while a fill is outstanding.
    a = 32'h0000_0C88;
    exp_rd_addr = {a[31:5], 5'b00000};
    ack_delay = 30;
    cpu_addr_i = a;
    cpu_MemRead_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("midmiss_enable", 256'(mem_enable_o), 256'(1'b1));
    chk("midmiss_stall", 256'(stall_o), 256'(1'b1));
    #2 rst_i = 1'b0;
    #1;
    chk("async_rst_enable", 256'(mem_enable_o), 256'(1'b0));
    chk("async_rst_stall", 256'(stall_o), 256'(1'b0));
    exp_q.delete();
    model_reset();
    cpu_MemRead_i = 1'b0;
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    do_access(a, 1'b0, 32'd0, 2);

    for (int n = 0; n < 300; n++) begin
      a = {20'd0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 2'b00};
      do_access(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 6));
    end

    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage of the pipelined CPU.
- Replaces the single-cycle data memory between the EX/MEM pipeline register and a slow off-chip line memory.
- Services word loads and stores from the CPU. Drives stall_o so PC, IF/ID, ID/EX, EX/MEM and MEM/WB hold while a miss is outstanding.
- Talks to off-chip memory through a 256-bit line-wide enable/ack handshake.

Parameters:
- ADDR_W, 32, byte-address width.
- LINE_W, 256, line width in bits (32 bytes, 8 words).
- NUM_LINES, 32, number of cache lines.
- Derived, not overridable: OFFSET_W=5 ([4:0]), INDEX_W=5 ([9:5]), TAG_W=ADDR_W-10=22 ([31:10]).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- cpu_addr_i  in  32  byte address (EX/MEM ALU result); bits [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request.
- cpu_data_o  out  32  load data.
- stall_o  out  1  pipeline stall.
- mem_addr_o  out  32  line address, low 5 bits always 0.
- mem_data_o  out  256  writeback line.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = line write, 0 = line read.
- mem_data_i  in  256  fill line.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE; all valid and dirty bits cleared.
  - stall_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0.
  - Tag and data array contents are don't-care.
- req = cpu_MemRead_i | cpu_MemWrite_i. If both are asserted, the access is treated as a write.
- hit = valid[idx] & (tag[idx]==cpu_addr_i[31:10]), combinational.
- cpu_data_o = word cpu_addr_i[4:2] of line[idx], combinational. It is valid whenever the access hits; otherwise don't-care and held at 0 when !cpu_MemRead_i.
- stall_o = req & ~(state==IDLE & hit), combinational. A hit completes in the same cycle with zero added latency.
- Write hit, IDLE: at the clock edge, word [4:2] of line[idx] takes cpu_data_i and dirty[idx] is set. The other 7 words are unchanged.
- FSM states: IDLE, WRITEBACK, READMISS, READMISSOK.
- IDLE:
  - req & !hit & valid & dirty goes to WRITEBACK.
  - req & !hit & !(valid & dirty) goes to READMISS.
  - Otherwise stay in IDLE.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {tag[idx], idx, 5'b0}; mem_data_o = line[idx].
  - On mem_ack_i, go to READMISS.
- READMISS:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {cpu_addr_i[31:5], 5'b0}.
  - On mem_ack_i, at that same edge: line[idx]=mem_data_i, tag[idx]=addr tag, valid=1, dirty=0. Then go to READMISSOK.
- READMISSOK: one cycle with stall_o=1, then IDLE. IDLE re-evaluates the access, which now hits. A pending store merges in that IDLE cycle and sets dirty.
- mem_* outputs are decoded from state. mem_enable_o is 0 in IDLE and READMISSOK.
- Memory must not issue a second ack for one request. mem_ack_i in IDLE or READMISSOK is ignored.
- Latency:
  - Clean miss: stall cycles = (cycles until ack) + 2.
  - Dirty miss: additionally includes the writeback handshake.
- The CPU holds cpu_addr_i, cpu_data_i and the request stable while stall_o=1, because the EX/MEM register is frozen.
- If req drops mid-miss (pipeline flush), the current handshake still completes. The FSM returns to IDLE with the line filled.
- rst_i low mid-miss aborts immediately: mem_enable_o drops asynchronously and the FSM enters IDLE. The memory side must tolerate the abandoned request.
- Index wrap: addresses differing only in tag bits alias to the same line and evict each other.

Decomposition:
- Shared package dcache_pkg:
  - State enum (IDLE, WRITEBACK, READMISS, READMISSOK).
  - Field widths and bit positions TAG_W, INDEX_W, OFFSET_W.
  - Line/word widths.
- One sub-module, dcache_sram, holds tag, valid, dirty and data arrays:
  - Async read.
  - Sync write with full-line and single-word write enables.
  - Valid/dirty bits cleared on rst_i.
- The FSM and hit logic live in dcache_controller.

Test Plan:
- Cold read miss:
  - Stimulus: read 0x0000_0044; memory returns line with word1=0xDEAD_BEEF, ack 10 cycles after enable.
  - Required response: mem_addr_o=0x40 and mem_write_o=0; stall_o high for 12 cycles; then cpu_data_o=0xDEAD_BEEF with stall_o=0.
- Read hit:
  - Stimulus: immediately read 0x0000_0048.
  - Required response: stall_o=0 that cycle; data is word2 of the filled line; mem_enable_o stays 0.
- Write hit then dirty eviction:
  - Stimulus: write 0x1234_5678 to 0x44; then read 0x0000_0444 (same index 2, new tag).
  - Required response: WRITEBACK with mem_addr_o=0x40, mem_write_o=1, mem_data_o[63:32]=0x1234_5678; then READMISS at 0x440.
- Write miss allocate:
  - Stimulus: write 0xA5A5_A5A5 to uncached 0x0000_0100.
  - Required response: line fill at 0x100; word 0 merged after READMISSOK; a later eviction writes back the merged word.
- Reset mid-miss:
  - Stimulus: assert rst_i low while in READMISS.
  - Required response: mem_enable_o and stall_o fall the same cycle (async); after release, a read of the previous address misses again because valid was cleared.
- Idle / stray ack:
  - Stimulus: no req; pulse mem_ack_i.
  - Required response: state stays IDLE; stall_o=0; no array writes.
